argmax_stream: RTL and testbench
================================

Name: argmax_stream

Overview:
- Parametrised, handshaked successor to the combinational max-index unit.
- Accepts a packed vector of N signed W-bit scores and scans it over several cycles, LANES elements per cycle.
- Returns the index and value of the maximum, or the minimum when mode selects it.
- Sits between the score-accumulation stage and the classification output; the output is held until the consumer takes it.

Parameters:
N, 10, number of elements per vector (N >= 2)
W, 26, element width, signed two's complement
LANES, 1, elements compared per scan cycle (1 <= LANES <= N-1)
IW, clog2(N), index width (4 for N=10)

Ports:
clk  in  1  rising-edge clock
GlobalReset  in  1  asynchronous active-low reset
in_valid  in  1  input vector present
in_ready  out  1  block can accept a vector
in_nums  in  N*W  element i at [i*W +: W]
in_mode  in  1  0 = argmax, 1 = argmin; sampled at accept
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
out_index  out  IW  index of winning element
out_value  out  W  value of winning element
busy  out  1  high in SCAN or DONE

Behaviour:
- Reset (GlobalReset=0, async): state=IDLE; out_valid=0, out_index=0, out_value=0, busy=0; in_ready=1 once reset deasserts.
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - in_ready=1.
  - Accept on in_valid&in_ready: register the full vector and the mode; best=elem0, best_idx=0, ptr=1; go to SCAN.
- SCAN:
  - in_ready=0.
  - Each cycle, compare elements ptr..min(ptr+LANES-1, N-1) against best, in ascending index order; ptr += LANES.
  - Lanes past N-1 are masked.
  - When ptr would reach >= N, update final best and go to DONE.
  - Scan cycles S = ceil((N-1)/LANES).
- DONE:
  - out_valid=1; out_index and out_value stable.
  - out_valid&out_ready -> IDLE on the same edge; out_valid drops on the next cycle.
  - No accept during DONE; no same-cycle bypass.
- Latency: accept at edge k -> out_valid high after edge k+S (N=10, LANES=1: S=9; LANES=3: S=3).
- Compare:
  - Signed comparison at full W bits.
  - Replace best only on strictly greater (max) or strictly less (min). Ties keep the lower index.
  - No saturation; values are never modified.
- Input changes while not in IDLE are ignored, since the vector is held in a register.
- Reset mid-SCAN or mid-DONE: immediate return to reset values; the in-flight result is discarded.
- out_ready held high while DONE completes in one cycle. out_ready low holds DONE indefinitely with outputs unchanged.

Test Plan:
1. N=10, LANES=1, mode=0, elements 0..9 = 32059, 32502, 43378, 28698, -46791, 59448, -5637, 37698, 24970, 58496 -> out_index=5, out_value=59448, out_valid after exactly 9 cycles.
2. Same vector, mode=1 -> out_index=4, out_value=-46791.
3. LANES=3, mode=0, elements -10, -15, -2, -100, -30, -10000, 200, -301234, -10000, -69 -> index 6, value 200, latency 3. With mode=1 -> index 7, value -301234.
4. All elements = -7 -> index 0 (tie rule) for both modes. Elements 3 and 8 both equal to the maximum 500 -> index 3.
5. Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid/out_index stable and in_ready=0. On out_ready=1, out_valid falls next cycle and in_ready=1. A new in_valid held during DONE is accepted only once back in IDLE.
6. Assert GlobalReset=0 during cycle 4 of SCAN -> outputs go to 0 immediately, without waiting for a clock edge. After release, a new vector completes with the correct result.

Source files
------------

// File: rtl/argmax_stream.sv
// Streaming argmax/argmin over a registered vector of N signed scores,
// scanning LANES elements per cycle and holding the winner until it is taken.
module argmax_stream #(
    parameter int N     = 10,
    parameter int W     = 26,
    parameter int LANES = 1,
    parameter int IW    = $clog2(N)
) (
    input  logic              clk,
    input  logic              GlobalReset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N*W-1:0]    in_nums,
    input  logic              in_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IW-1:0]     out_index,
    output logic [W-1:0]      out_value,
    output logic              busy,
    output logic [1:0]        dbg_state_o
);

    // Handshakes: a transfer happens on a rising clk edge where valid and ready
    // are both high; valid never depends on ready, and DONE holds its outputs
    // stable until out_ready is seen.

    localparam int PW = $clog2(N + LANES + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [N*W-1:0]       vec_q, vec_d;
    logic                 mode_q, mode_d;
    logic signed [W-1:0]  best_q, best_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [PW-1:0]        ptr_q, ptr_d;

    logic signed [W-1:0]  elems [N];
    logic signed [W-1:0]  cand_val;
    logic [IW-1:0]        cand_idx;
    logic signed [W-1:0]  elem;
    logic [IW-1:0]        lane_c;
    logic                 better;
    int                   lane;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            elems[i] = vec_q[i*W +: W];
        end
    end

    // Lanes are folded in ascending index order, so a strict compare keeps the
    // lowest index on ties; lanes beyond N-1 never win.
    always_comb begin
        cand_val = best_q;
        cand_idx = idx_q;
        elem     = '0;
        lane_c   = '0;
        better   = 1'b0;
        lane     = 0;
        for (int l = 0; l < LANES; l++) begin
            lane   = int'(ptr_q) + l;
            lane_c = (lane < N) ? IW'(lane) : IW'(N - 1);
            elem   = elems[lane_c];
            better = mode_q ? (elem < cand_val) : (elem > cand_val);
            if ((lane < N) && better) begin
                cand_val = elem;
                cand_idx = lane_c;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        mode_d  = mode_q;
        best_d  = best_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    vec_d   = in_nums;
                    mode_d  = in_mode;
                    best_d  = in_nums[W-1:0];
                    idx_d   = '0;
                    ptr_d   = PW'(1);
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                best_d = cand_val;
                idx_d  = cand_idx;
                ptr_d  = ptr_q + PW'(LANES);
                if (int'(ptr_q) + LANES >= N) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge GlobalReset) begin
        if (!GlobalReset) begin
            state_q <= S_IDLE;
            vec_q   <= '0;
            mode_q  <= 1'b0;
            best_q  <= '0;
            idx_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            mode_q  <= mode_d;
            best_q  <= best_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
        end
    end

    assign in_ready    = (state_q == S_IDLE);
    assign out_valid   = (state_q == S_DONE);
    assign busy        = (state_q != S_IDLE);
    assign out_index   = idx_q;
    assign out_value   = best_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_argmax_stream.sv
// Scoreboard bench for argmax_stream: one LANES=1 and one LANES=3 instance
// driven with hand-computed directed vectors.
module tb_argmax_stream;

    localparam int N  = 10;
    localparam int W  = 26;
    localparam int IW = 4;

    logic clk;
    logic GlobalReset;
    int   cyc;

    logic              in_valid1, in_ready1, in_mode1, out_valid1, out_ready1, busy1;
    logic [N*W-1:0]    in_nums1;
    logic [IW-1:0]     out_index1;
    logic [W-1:0]      out_value1;
    logic [1:0]        dbg1;

    logic              in_valid3, in_ready3, in_mode3, out_valid3, out_ready3, busy3;
    logic [N*W-1:0]    in_nums3;
    logic [IW-1:0]     out_index3;
    logic [W-1:0]      out_value3;
    logic [1:0]        dbg3;

    logic [IW+W-1:0]   exp_q1[$];
    logic [IW+W-1:0]   exp_q3[$];
    int                acc_q1[$];
    int                acc_q3[$];

    int n_vec;
    int n_fail;
    int vecs [7][N];
    logic ov1_prev, ov3_prev;

    argmax_stream #(.N(N), .W(W), .LANES(1), .IW(IW)) u1 (
        .clk(clk), .GlobalReset(GlobalReset),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_nums(in_nums1), .in_mode(in_mode1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_index(out_index1),
        .out_value(out_value1), .busy(busy1), .dbg_state_o(dbg1)
    );

    argmax_stream #(.N(N), .W(W), .LANES(3), .IW(IW)) u3 (
        .clk(clk), .GlobalReset(GlobalReset),
        .in_valid(in_valid3), .in_ready(in_ready3), .in_nums(in_nums3), .in_mode(in_mode3),
        .out_valid(out_valid3), .out_ready(out_ready3), .out_index(out_index3),
        .out_value(out_value3), .busy(busy3), .dbg_state_o(dbg3)
    );

    // Clock and cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint got, input longint exp);
        n_vec++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_vec++;
        n_fail++;
        $display("FAIL %s: got timeout expected DUT response (t=%0t)", name, $time);
    endtask

    function automatic logic [N*W-1:0] pack(input int vid);
        logic [N*W-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) r[i*W +: W] = W'(vecs[vid][i]);
        return r;
    endfunction

    // Driver: present one vector, push the expected result at the accept edge
    task automatic send(input bit sel, input int vid, input bit mode, input int ei, input int ev);
        int t;
        t = 0;
        @(negedge clk);
        while (!(sel ? in_ready3 : in_ready1) && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) begin
            timeout("in_ready");
            return;
        end
        if (sel) begin
            in_valid3 = 1'b1; in_nums3 = pack(vid); in_mode3 = mode;
        end else begin
            in_valid1 = 1'b1; in_nums1 = pack(vid); in_mode1 = mode;
        end
        @(posedge clk);
        #1;
        if (sel) begin
            exp_q3.push_back({IW'(ei), W'(ev)});
            acc_q3.push_back(cyc);
        end else begin
            exp_q1.push_back({IW'(ei), W'(ev)});
            acc_q1.push_back(cyc);
        end
        @(negedge clk);
        if (sel) in_valid3 = 1'b0;
        else     in_valid1 = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp_q1.size() != 0 || exp_q3.size() != 0) && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) timeout("drain");
        @(negedge clk);
    endtask

    // Monitors: sample just after inputs settle, ahead of the next rising edge
    initial ov1_prev = 1'b0;
    always begin
        logic [IW+W-1:0] e;
        int a;
        @(negedge clk);
        #2;
        if (out_valid1 && !ov1_prev) begin
            if (acc_q1.size() == 0) timeout("lat1_unexpected");
            else begin
                a = acc_q1.pop_front();
                check("lat1", cyc - a, 9);
            end
        end
        ov1_prev = out_valid1;
        if (out_valid1 && out_ready1) begin
            if (exp_q1.size() == 0) timeout("res1_unexpected");
            else begin
                e = exp_q1.pop_front();
                check("idx1", out_index1, e[W +: IW]);
                check("val1", $signed(out_value1), $signed(e[W-1:0]));
            end
        end
    end

    initial ov3_prev = 1'b0;
    always begin
        logic [IW+W-1:0] e;
        int a;
        @(negedge clk);
        #2;
        if (out_valid3 && !ov3_prev) begin
            if (acc_q3.size() == 0) timeout("lat3_unexpected");
            else begin
                a = acc_q3.pop_front();
                check("lat3", cyc - a, 3);
            end
        end
        ov3_prev = out_valid3;
        if (out_valid3 && out_ready3) begin
            if (exp_q3.size() == 0) timeout("res3_unexpected");
            else begin
                e = exp_q3.pop_front();
                check("idx3", out_index3, e[W +: IW]);
                check("val3", $signed(out_value3), $signed(e[W-1:0]));
            end
        end
    end

    initial begin
        int t;
        n_vec  = 0;
        n_fail = 0;
        vecs[0] = '{32059, 32502, 43378, 28698, -46791, 59448, -5637, 37698, 24970, 58496};
        vecs[1] = '{-10, -15, -2, -100, -30, -10000, 200, -301234, -10000, -69};
        vecs[2] = '{-7, -7, -7, -7, -7, -7, -7, -7, -7, -7};
        vecs[3] = '{0, 10, 20, 500, 40, 50, 60, 70, 500, 90};
        vecs[4] = '{0, 0, -5, 0, 0, 0, 0, 0, 0, -5};
        vecs[5] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 1000000};
        vecs[6] = '{0, 0, 0, 0, 33554431, 0, 0, -33554432, 0, 0};

        in_valid1 = 0; in_nums1 = '0; in_mode1 = 0; out_ready1 = 1;
        in_valid3 = 0; in_nums3 = '0; in_mode3 = 0; out_ready3 = 1;
        GlobalReset = 1'b0;

        #3;
        check("rst_ov1", out_valid1, 0);
        check("rst_idx1", out_index1, 0);
        check("rst_val1", out_value1, 0);
        check("rst_busy1", busy1, 0);
        check("rst_ov3", out_valid3, 0);
        check("rst_busy3", busy3, 0);
        @(negedge clk);
        @(negedge clk);
        GlobalReset = 1'b1;
        @(negedge clk);
        check("rdy1_after_rst", in_ready1, 1);
        check("rdy3_after_rst", in_ready3, 1);

        // LANES=1 directed vectors
        send(0, 0, 0, 5, 59448);
        send(0, 0, 1, 4, -46791);
        send(0, 2, 0, 0, -7);
        send(0, 2, 1, 0, -7);
        send(0, 3, 0, 3, 500);
        send(0, 4, 1, 2, -5);
        send(0, 5, 0, 9, 1000000);
        send(0, 6, 1, 7, -33554432);

        // LANES=3 directed vectors
        send(1, 1, 0, 6, 200);
        send(1, 1, 1, 7, -301234);
        send(1, 2, 0, 0, -7);
        send(1, 2, 1, 0, -7);
        send(1, 3, 0, 3, 500);
        send(1, 5, 0, 9, 1000000);
        send(1, 5, 1, 0, 1);
        send(1, 6, 0, 4, 33554431);
        drain();

        // Backpressure in DONE with a new vector waiting
        out_ready1 = 1'b0;
        send(0, 0, 0, 5, 59448);
        t = 0;
        while (!out_valid1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) timeout("bp_out_valid");
        in_valid1 = 1'b1; in_nums1 = pack(3); in_mode1 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_ov", out_valid1, 1);
            check("bp_idx", out_index1, 5);
            check("bp_val", $signed(out_value1), 59448);
            check("bp_in_ready", in_ready1, 0);
        end
        out_ready1 = 1'b1;
        @(negedge clk);
        check("bp_ov_drop", out_valid1, 0);
        check("bp_in_ready_back", in_ready1, 1);
        exp_q1.push_back({IW'(3), W'(500)});
        acc_q1.push_back(cyc + 1);
        @(negedge clk);
        check("bp_held_accept", busy1, 1);
        in_valid1 = 1'b0;
        drain();

        // Asynchronous reset during the fourth scan cycle
        in_valid1 = 1'b1; in_nums1 = pack(5); in_mode1 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("scan_busy", busy1, 1);
        #1;
        GlobalReset = 1'b0;
        #1;
        check("mid_rst_ov", out_valid1, 0);
        check("mid_rst_idx", out_index1, 0);
        check("mid_rst_val", out_value1, 0);
        check("mid_rst_busy", busy1, 0);
        check("mid_rst_state", dbg1, 0);
        @(negedge clk);
        @(negedge clk);
        GlobalReset = 1'b1;
        @(negedge clk);
        check("post_rst_ready", in_ready1, 1);
        send(0, 6, 0, 4, 33554431);
        send(0, 1, 1, 7, -301234);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
